// File: rtl/video_pattern_gen_if.sv
// Pixel/timing bus between a video source and its consumer: 8-bit RGB plus
// dv/hs/vs and a frame-start marker, one pixel per clock.
interface video_pattern_gen_if;
    logic [7:0] tx_red;
    logic [7:0] tx_green;
    logic [7:0] tx_blue;
    logic       tx_dv;
    logic       tx_hs;
    logic       tx_vs;
    logic       frame_start;

    modport master (
        output tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_start
    );

    modport slave (
        input  tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: programmable raster timing plus one of four test patterns
// (colour bars, gray ramp, checkerboard, flat fill). Every output is registered
// one cycle after the counter state it describes. Active video sits at the start
// of each line and frame. Dropping en returns the block to its idle state and
// the next enabled cycle starts a fresh frame.
// Optional macro PATGEN_BOX_EN adds a bouncing 16x16 white box overlay.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                tx_clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          pattern_sel,
    input  logic [23:0]         fill_rgb,
    video_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    sel_q, sel_d;
    logic [23:0]   fill_q, fill_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          dv_q, dv_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

    logic          first_px, active;
    logic [1:0]    eff_sel;
    logic [23:0]   eff_fill, pix;

`ifdef PATGEN_BOX_EN
    localparam logic [HW-1:0] BOX_X_MAX = HW'(H_ACTIVE - 16);
    localparam logic [VW-1:0] BOX_Y_MAX = VW'(V_ACTIVE - 16);
    // bx/by hold the position for the next frame; cur_* is the frame being drawn
    logic [HW-1:0] bx_q, bx_d, cur_bx_q, cur_bx_d, box_x;
    logic [VW-1:0] by_q, by_d, cur_by_q, cur_by_d, box_y;
    logic          dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
`endif

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    // Next counter/shadow state and the registered pixel for the current position
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        sel_d     = sel_q;
        fill_d    = fill_q;
        rgb_d     = 24'h0;
        dv_d      = 1'b0;
        hs_d      = ~HS_POL;
        vs_d      = ~VS_POL;
        fs_d      = 1'b0;
        first_px  = (h_cnt_q == '0) && (v_cnt_q == '0);
        active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        // Pixel (0,0) already uses the freshly sampled config so the whole frame agrees
        eff_sel   = first_px ? pattern_sel : sel_q;
        eff_fill  = first_px ? fill_rgb : fill_q;
        pix       = 24'h0;
`ifdef PATGEN_BOX_EN
        bx_d      = bx_q;
        by_d      = by_q;
        cur_bx_d  = cur_bx_q;
        cur_by_d  = cur_by_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        box_x     = first_px ? bx_q : cur_bx_q;
        box_y     = first_px ? by_q : cur_by_q;
`endif
        if (!en) begin
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else begin
            if (first_px) begin
                sel_d  = pattern_sel;
                fill_d = fill_rgb;
            end
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
            // Bar index advances every BAR_W active pixels, restarting each line
            if (h_cnt_q == H_LAST) begin
                bar_pix_d = '0;
                bar_idx_d = '0;
            end else if (h_cnt_q < H_ACT) begin
                if (bar_pix_q == BAR_LAST) begin
                    bar_pix_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_pix_d = bar_pix_q + BW'(1);
                end
            end
            case (eff_sel)
                2'd0:    pix = bar_colour(bar_idx_q);
                2'd1:    pix = {3{8'(h_cnt_q)}};
                2'd2:    pix = (((32'(h_cnt_q) ^ 32'(v_cnt_q)) & 32'd32) == 32'd0) ? 24'hFFFFFF : 24'h0;
                default: pix = eff_fill;
            endcase
`ifdef PATGEN_BOX_EN
            if ((h_cnt_q >= box_x) && (h_cnt_q < box_x + HW'(16)) &&
                (v_cnt_q >= box_y) && (v_cnt_q < box_y + VW'(16)))
                pix = 24'hFFFFFF;
            // Bounce: when the step would leave the active area, reverse and step
            // the other way (holding only if that is blocked too)
            if (first_px) begin
                cur_bx_d = bx_q;
                cur_by_d = by_q;
                if (!dx_neg_q) begin
                    if (bx_q >= BOX_X_MAX) begin
                        dx_neg_d = 1'b1;
                        bx_d     = (bx_q == '0) ? bx_q : bx_q - HW'(1);
                    end else begin
                        bx_d = bx_q + HW'(1);
                    end
                end else begin
                    if (bx_q == '0) begin
                        dx_neg_d = 1'b0;
                        bx_d     = (bx_q >= BOX_X_MAX) ? bx_q : bx_q + HW'(1);
                    end else begin
                        bx_d = bx_q - HW'(1);
                    end
                end
                if (!dy_neg_q) begin
                    if (by_q >= BOX_Y_MAX) begin
                        dy_neg_d = 1'b1;
                        by_d     = (by_q == '0) ? by_q : by_q - VW'(1);
                    end else begin
                        by_d = by_q + VW'(1);
                    end
                end else begin
                    if (by_q == '0) begin
                        dy_neg_d = 1'b0;
                        by_d     = (by_q >= BOX_Y_MAX) ? by_q : by_q + VW'(1);
                    end else begin
                        by_d = by_q - VW'(1);
                    end
                end
            end
`endif
            rgb_d = active ? pix : 24'h0;
            dv_d  = active;
            hs_d  = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
            vs_d  = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
            fs_d  = first_px;
        end
    end

    // State and output registers with asynchronous reset to the idle state
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            sel_q     <= '0;
            fill_q    <= '0;
            rgb_q     <= '0;
            dv_q      <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            fs_q      <= 1'b0;
`ifdef PATGEN_BOX_EN
            bx_q      <= '0;
            by_q      <= '0;
            cur_bx_q  <= '0;
            cur_by_q  <= '0;
            dx_neg_q  <= 1'b0;
            dy_neg_q  <= 1'b0;
`endif
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            sel_q     <= sel_d;
            fill_q    <= fill_d;
            rgb_q     <= rgb_d;
            dv_q      <= dv_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
`ifdef PATGEN_BOX_EN
            bx_q      <= bx_d;
            by_q      <= by_d;
            cur_bx_q  <= cur_bx_d;
            cur_by_q  <= cur_by_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
`endif
        end
    end

    assign vid.tx_red      = rgb_q[23:16];
    assign vid.tx_green    = rgb_q[15:8];
    assign vid.tx_blue     = rgb_q[7:0];
    assign vid.tx_dv       = dv_q;
    assign vid.tx_hs       = hs_q;
    assign vid.tx_vs       = vs_q;
    assign vid.frame_start = fs_q;
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Video source that emits the same pixel/timing stream the HDMI transmitter consumes: 8-bit RGB plus dv/hs/vs, one pixel per clock.
- Generates programmable raster timing and one of four test patterns.
- Drives hdmi_tx directly when there is no HDMI input. Also provides a known stimulus for the median filter path in place of the receiver.

Parameters:
H_ACTIVE, 1280, active pixels per line (must be a multiple of 8)
H_FP, 110, horizontal front porch in pixels
H_SYNC, 40, horizontal sync width in pixels
H_BP, 220, horizontal back porch in pixels
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch in lines
V_SYNC, 5, vertical sync width in lines
V_BP, 20, vertical back porch in lines
HS_POL, 1, active level of tx_hs
VS_POL, 1, active level of tx_vs

Ports:
tx_clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
en  in  1  run enable; counters run only while high
pattern_sel  in  2  0=colour bars, 1=gray ramp, 2=checkerboard, 3=flat fill
fill_rgb  in  24  flat fill colour {r,g,b}, used when pattern_sel=3
tx_red  out  8  red pixel
tx_green  out  8  green pixel
tx_blue  out  8  blue pixel
tx_dv  out  1  active video
tx_hs  out  1  horizontal sync
tx_vs  out  1  vertical sync
frame_start  out  1  one-cycle pulse aligned with the first active pixel of each frame

Behaviour:
- Line and frame totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. On wrap, v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, i.e. active video comes first in each line and frame.
- hs is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vs is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vs edges are aligned to h_cnt==0.
- All outputs are registered, with exactly 1 cycle latency from counter state to outputs. Counter advance, output register and box position (when enabled) all update on the same tx_clk edge.
- Reset / idle state: counters=0, tx_dv=0, rgb=0, tx_hs=~HS_POL, tx_vs=~VS_POL, frame_start=0.
  - Applies asynchronously on rst.
  - Also applies synchronously on any cycle where en=0.
  - Dropping en mid-frame aborts the frame. The next cycle with en=1 starts a new frame at h=0, v=0.
- Config sampling: pattern_sel and fill_rgb are captured into shadow registers only when h_cnt==0 and v_cnt==0 with en=1. A pattern change never tears mid-frame.
- frame_start: 1 on the output cycle of pixel (0,0), 0 otherwise.
- rgb is 0 whenever tx_dv=0.
- Pattern 0, colour bars:
  - 8 equal bars, bar width H_ACTIVE/8, tracked by a bar pixel counter and a 3-bit bar index (no divider).
  - Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Pattern 1, gray ramp: r=g=b=h_cnt[7:0]; wraps every 256 pixels.
- Pattern 2, checkerboard: 32x32 squares; FFFFFF when h_cnt[5]^v_cnt[5]=0, else 000000.
- Pattern 3: flat shadowed fill_rgb.

Optional Feature:
- Macro: PATGEN_BOX_EN.
- Defined:
  - A 16x16 white (FFFFFF) box overlays every pattern inside active video.
  - Box top-left (bx,by) resets to (0,0), moves by (dx,dy), both initially +1.
  - Update happens once per frame on the same edge that emits frame_start.
  - Direction reverses when the next step would leave the active area (bx+16>H_ACTIVE or by+16>V_ACTIVE); on that frame the reversed step is applied.
  - Overlay has priority over the pattern; latency stays 1 cycle.
- Undefined: no box logic; output is the pure pattern.

Test Plan:
- Bench params: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24), V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=12).
- Timing: rst then en=1 for 2 frames -> per line: tx_dv high 16 cycles, low 8; tx_hs high exactly 3 cycles starting 18 cycles after tx_dv rises. Per frame: tx_vs high 48 cycles starting at line 9. Period is 288 cycles. frame_start pulses every 288 cycles.
- Colour bars: sel=0 -> line pixels are FFFFFF x2, FFFF00 x2, 00FFFF x2, 00FF00 x2, FF00FF x2, FF0000 x2, 0000FF x2, 000000 x2. rgb=0 during blanking.
- Config sampling: switch sel 0->1 mid-frame -> current frame stays bars. Next frame is ramp: pixel n has r=g=b=n (0..15).
- Flat fill: sel=3, fill_rgb=123456 -> all active pixels 123456. A change to fill_rgb mid-frame takes effect only from the next frame_start.
- Enable mid-frame: drop en at line 4, pixel 5 -> next cycle tx_dv=0, tx_hs=0, tx_vs=0. Re-raise en -> the output cycle after re-enable shows frame_start=1 with pixel (0,0).
- Async reset: assert rst asynchronously mid-line -> outputs reach reset values without waiting for a clock edge. After release, the first frame matches the timing scenario.
- With PATGEN_BOX_EN (H_ACTIVE=32, V_ACTIVE=24): frame 0 box at (0,0); frame 1 at (1,1). Box x reverses after reaching bx=16 (32-16).
